// File: rtl/sha_seq.sv
// sha_seq: word FIFO plus sequencer that feeds 512-bit blocks to a hash core.
// Ports: CLK_I/RST_I, start/nblk job request, wr_en/wr_dat FIFO push,
//   fifo_full/busy/ovf status, hash_vld/hash_o result,
//   core_init/core_vld/core_din to core, core_done/core_hash from core.
module sha_seq #(
  parameter int DEPTH = 16,
  parameter int BLKW  = 8
) (
  input  logic            CLK_I,
  input  logic            RST_I,
  input  logic            start,
  input  logic [BLKW-1:0] nblk,
  input  logic            wr_en,
  input  logic [31:0]     wr_dat,
  output logic            fifo_full,
  output logic            busy,
  output logic            ovf,
  output logic            hash_vld,
  output logic [255:0]    hash_o,
  output logic            core_init,
  output logic            core_vld,
  output logic [31:0]     core_din,
  input  logic            core_done,
  input  logic [255:0]    core_hash
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]     CNT_ONE  = 1;
  localparam logic [AW-1:0]   PTR_ONE  = 1;
  localparam logic [BLKW-1:0] BLK_ONE  = 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FEED,
    WAIT,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]     mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     cnt;
  logic [BLKW-1:0] blk_left;
  logic [3:0]      word_cnt;

  logic empty;
  logic pop;
  logic push_ok;
  logic drop;
  logic start_acc;
  logic blk_dec;
  logic wc_clr;
  logic hash_ld;

  assign empty     = (cnt == '0);
  assign fifo_full = (cnt == FULL_CNT);
  assign busy      = (state_q != IDLE);

  // A push into a full FIFO survives only if a pop frees a slot
  // on the same edge.
  assign push_ok   = wr_en & (~fifo_full | pop);
  assign drop      = wr_en & fifo_full & ~pop;
  assign start_acc = (state_q == IDLE) & start & (nblk != '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    blk_dec = 1'b0;
    wc_clr  = 1'b0;
    hash_ld = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_acc) state_d = INIT;
      end
      INIT: begin
        wc_clr  = 1'b1;
        state_d = FEED;
      end
      FEED: begin
        if (!empty) begin
          pop = 1'b1;
          if (word_cnt == 4'd15) begin
            blk_dec = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (core_done) begin
          if (blk_left != '0) begin
            wc_clr  = 1'b1;
            state_d = FEED;
          end else begin
            hash_ld = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK_I) begin
    if (push_ok) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      if (push_ok & ~pop)      cnt <= cnt + CNT_ONE;
      else if (pop & ~push_ok) cnt <= cnt - CNT_ONE;
    end
  end

  // Strobes are registered from the next state so each one is high
  // for exactly the cycle its state is occupied.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      blk_left  <= '0;
      word_cnt  <= '0;
      ovf       <= 1'b0;
      hash_o    <= '0;
      hash_vld  <= 1'b0;
      core_init <= 1'b0;
      core_vld  <= 1'b0;
      core_din  <= '0;
    end else begin
      if (start_acc)    blk_left <= nblk;
      else if (blk_dec) blk_left <= blk_left - BLK_ONE;
      if (wc_clr)   word_cnt <= '0;
      else if (pop) word_cnt <= word_cnt + 4'd1;
      ovf       <= (ovf & ~start_acc) | drop;
      if (hash_ld) hash_o <= core_hash;
      hash_vld  <= (state_d == DONE);
      core_init <= (state_d == INIT);
      core_vld  <= pop;
      if (pop) core_din <= mem[rptr];
    end
  end

endmodule

// File: tb/tb_sha_seq.sv
// tb_sha_seq: randomized scoreboard bench for sha_seq.
// A behavioural hash-core model answers each 16-word block.
module tb_sha_seq;

  localparam int DEPTH = 16;
  localparam int BLKW  = 8;

  logic            CLK_I = 1'b0;
  logic            RST_I = 1'b1;
  logic            start = 1'b0;
  logic [BLKW-1:0] nblk = '0;
  logic            wr_en = 1'b0;
  logic [31:0]     wr_dat = '0;
  logic            fifo_full;
  logic            busy;
  logic            ovf;
  logic            hash_vld;
  logic [255:0]    hash_o;
  logic            core_init;
  logic            core_vld;
  logic [31:0]     core_din;
  logic            core_done;
  logic [255:0]    core_hash;

  sha_seq #(.DEPTH(DEPTH), .BLKW(BLKW)) dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .start(start),
    .nblk(nblk),
    .wr_en(wr_en),
    .wr_dat(wr_dat),
    .fifo_full(fifo_full),
    .busy(busy),
    .ovf(ovf),
    .hash_vld(hash_vld),
    .hash_o(hash_o),
    .core_init(core_init),
    .core_vld(core_vld),
    .core_din(core_din),
    .core_done(core_done),
    .core_hash(core_hash)
  );

  always #5 CLK_I = ~CLK_I;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int n_init = 0;
  int exp_init = 0;
  int n_hash = 0;
  int n_vld = 0;
  int vld_first = -1;
  int vld_last = -1;
  int job_nblk = 0;
  int cm_wc = 0;
  int cm_blk = 0;
  int cm_delay = 0;
  bit cm_pending = 1'b0;

  logic [31:0]  exp_word[$];
  logic [255:0] exp_hash[$];

  always @(posedge CLK_I) cyc++;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops scoreboard queues whenever the DUT presents data.
  initial begin
    forever begin
      @(negedge CLK_I);
      if (!RST_I) begin
        if (core_init | core_vld | hash_vld)
          check("strobe_excl", $countones({core_init, core_vld, hash_vld}), 1);
        if (core_init) n_init++;
        if (core_vld) begin
          n_vld++;
          if (vld_first < 0) vld_first = cyc;
          vld_last = cyc;
          if (exp_word.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL core_din: unexpected word %0h", core_din);
          end else begin
            check("core_din", core_din, exp_word.pop_front());
          end
        end
        if (hash_vld) begin
          n_hash++;
          if (exp_hash.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL hash_o: unexpected hash %0h", hash_o);
          end else begin
            check("hash_o", hash_o, exp_hash.pop_front());
          end
        end
      end
    end
  end

  // Hash-core model: after 16 words, answers with a random digest.
  // The digest of the job's last block is the expected hash_o.
  initial begin
    logic [255:0] h;
    core_done = 1'b0;
    core_hash = '0;
    forever begin
      @(negedge CLK_I);
      core_done = 1'b0;
      if (RST_I) begin
        cm_wc = 0;
        cm_blk = 0;
        cm_pending = 1'b0;
      end else begin
        if (core_init) begin
          cm_wc = 0;
          cm_blk = 0;
        end
        if (cm_pending) begin
          check("vld_in_wait", core_vld, 1'b0);
          if (cm_delay == 0) begin
            for (int k = 0; k < 8; k++) h[k*32 +: 32] = $urandom();
            core_hash = h;
            core_done = 1'b1;
            cm_pending = 1'b0;
            cm_blk++;
            if (cm_blk == job_nblk) exp_hash.push_back(h);
          end else begin
            cm_delay--;
          end
        end else if (core_vld) begin
          cm_wc++;
          if (cm_wc == 16) begin
            cm_wc = 0;
            cm_pending = 1'b1;
            cm_delay = $urandom_range(1, 4);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input bit acc);
    wr_en = 1'b1;
    wr_dat = w;
    tick();
    wr_en = 1'b0;
    if (acc) exp_word.push_back(w);
  endtask

  task automatic start_job(input int n, input bit acc);
    start = 1'b1;
    nblk = BLKW'(n);
    tick();
    start = 1'b0;
    if (acc) begin
      job_nblk = n;
      exp_init++;
    end
  endtask

  task automatic wait_hash(input int target);
    int k = 0;
    while (n_hash < target && k < 3000) begin
      tick();
      k++;
    end
    check("hash_seen", n_hash, target);
  endtask

  task automatic wait_vld(input int target);
    int k = 0;
    while (n_vld < target && k < 3000) begin
      @(negedge CLK_I);
      #1;
      k++;
    end
    check("vld_seen", n_vld, target);
  endtask

  task automatic outs_zero(input string tag);
    check({tag, "_flags"},
          {busy, fifo_full, ovf, hash_vld, core_init, core_vld}, 0);
    check({tag, "_hash"}, hash_o, 0);
    check({tag, "_din"}, core_din, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int base;
    repeat (3) @(posedge CLK_I);
    #1;
    outs_zero("reset");
    @(negedge CLK_I);
    RST_I = 1'b0;
    tick();

    // Pre-loaded single block, words 1..16
    for (int i = 1; i <= 16; i++) push(32'(i), 1'b1);
    vld_first = -1;
    start_job(1, 1'b1);
    wait_hash(1);
    check("busy_after_1", busy, 1'b0);
    check("vld_burst", vld_last - vld_first, 15);
    check("init_cnt_1", n_init, exp_init);

    // Two blocks, host trickles one word every 3 cycles
    start_job(2, 1'b1);
    for (int i = 0; i < 32; i++) begin
      push($urandom(), 1'b1);
      tick();
      tick();
    end
    wait_hash(2);
    check("busy_after_2", busy, 1'b0);
    repeat (5) tick();
    check("single_hash", n_hash, 2);

    // Overflow in IDLE: 17th word dropped
    for (int i = 0; i < DEPTH; i++) begin
      push($urandom(), 1'b1);
      if (i == DEPTH - 2) check("not_full", fifo_full, 1'b0);
    end
    check("full_at_depth", fifo_full, 1'b1);
    check("ovf_before", ovf, 1'b0);
    push($urandom(), 1'b0);
    check("ovf_set", ovf, 1'b1);
    check("full_after_drop", fifo_full, 1'b1);
    start_job(1, 1'b1);
    check("ovf_clr", ovf, 1'b0);
    wait_hash(3);

    // Full FIFO with simultaneous push/pop during FEED
    for (int i = 0; i < DEPTH; i++) push($urandom(), 1'b1);
    start_job(2, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) begin
      push($urandom(), 1'b1);
      check("full_hold", fifo_full, 1'b1);
    end
    check("ovf_pushpop", ovf, 1'b0);
    wait_hash(4);

    // nblk=0 ignored; start during WAIT ignored
    start_job(0, 1'b0);
    repeat (3) tick();
    check("busy_nblk0", busy, 1'b0);
    check("init_nblk0", n_init, exp_init);
    for (int i = 0; i < 16; i++) push($urandom(), 1'b1);
    start_job(1, 1'b1);
    begin
      int k = 0;
      while (!cm_pending && k < 200) begin
        @(negedge CLK_I);
        #1;
        k++;
      end
    end
    check("reach_wait", cm_pending, 1'b1);
    start_job(3, 1'b0);
    wait_hash(5);
    check("busy_after_5", busy, 1'b0);
    check("init_cnt_5", n_init, exp_init);

    // Reset during FEED after word 7
    for (int i = 0; i < 16; i++) push($urandom(), 1'b1);
    start_job(1, 1'b1);
    base = n_vld;
    wait_vld(base + 7);
    RST_I = 1'b1;
    #1;
    outs_zero("mid_reset");
    exp_word.delete();
    repeat (2) tick();
    outs_zero("held_reset");
    check("no_hash_rst", n_hash, 5);
    @(negedge CLK_I);
    RST_I = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) push($urandom(), 1'b1);
    start_job(1, 1'b1);
    wait_hash(6);

    // Random jobs with random host gaps
    for (int j = 0; j < 4; j++) begin
      int n;
      n = $urandom_range(1, 3);
      start_job(n, 1'b1);
      for (int i = 0; i < 16 * n; i++) begin
        push($urandom(), 1'b1);
        repeat ($urandom_range(0, 2)) tick();
      end
      wait_hash(7 + j);
      check("busy_rand", busy, 1'b0);
    end

    repeat (5) tick();
    check("word_q_empty", exp_word.size(), 0);
    check("hash_q_empty", exp_hash.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha_seq.md
SHA_SEQ -- requirements
Module: sha_seq

Interface
REQ-001 Parameter DEPTH, default 16, sets word-FIFO depth; SHALL be a power of 2 and at least 16.
REQ-002 Parameter BLKW, default 8, sets the width of the block-count input.
REQ-003 CLK_I  in  1  single system clock; all logic is rising-edge.
REQ-004 RST_I  in  1  asynchronous active-high reset.
REQ-005 start  in  1  one-cycle job-start pulse.
REQ-006 nblk  in  BLKW  number of 512-bit blocks in the job, sampled on an accepted start.
REQ-007 wr_en  in  1  pushes wr_dat into the word FIFO.
REQ-008 wr_dat  in  32  message word, already padded by the host.
REQ-009 fifo_full  out  1  FIFO holds DEPTH words.
REQ-010 busy  out  1  job in progress (state not IDLE).
REQ-011 ovf  out  1  sticky flag: a push was dropped.
REQ-012 hash_vld  out  1  one-cycle pulse when hash_o is updated.
REQ-013 hash_o  out  256  final digest of the last job.
REQ-014 core_init  out  1  init pulse to the hash core.
REQ-015 core_vld  out  1  core_din valid strobe.
REQ-016 core_din  out  32  word to the hash core.
REQ-017 core_done  in  1  core block-complete pulse.
REQ-018 core_hash  in  256  core digest, valid while core_done=1.

Function
REQ-019 FSM states SHALL be IDLE, INIT, FEED, WAIT and DONE.
REQ-020 In IDLE, start=1 with nblk!=0 SHALL latch nblk into blk_left and go to INIT; start with nblk=0 SHALL be ignored.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 INIT SHALL last exactly one cycle with core_init=1, clear word_cnt, then go to FEED.
REQ-023 FEED, FIFO not empty: SHALL pop one word per cycle, drive core_vld=1 and core_din=popped word in the same cycle, and increment word_cnt.
REQ-024 FEED, FIFO empty: SHALL stall with core_vld=0 and no timeout.
REQ-025 When the 16th word of a block is issued, the FSM SHALL go to WAIT and decrement blk_left.
REQ-026 In WAIT, core_done=1 SHALL go to FEED with word_cnt=0 if blk_left!=0, otherwise to DONE with hash_o<=core_hash.
REQ-027 core_done outside WAIT SHALL be ignored.
REQ-028 DONE SHALL last exactly one cycle with hash_vld=1, then go to IDLE.
REQ-029 core_init, core_vld and hash_vld SHALL be registered outputs, glitch-free, and never high together.
REQ-030 Push latency: a word written at cycle N SHALL be poppable at cycle N+1.
REQ-031 Push when full with no pop in the same cycle: word SHALL be dropped and ovf set.
REQ-032 Push when full with a pop in the same cycle: push SHALL be accepted and fifo_full SHALL stay 1.
REQ-033 Push when empty with no pop: SHALL be accepted.
REQ-034 FIFO read and write pointers SHALL wrap modulo DEPTH; occupancy counter SHALL be log2(DEPTH)+1 bits.
REQ-035 Writes SHALL be accepted in every state, including IDLE pre-load.
REQ-036 ovf SHALL clear on an accepted start and SHALL not otherwise affect sequencing.
REQ-037 blk_left SHALL be BLKW bits and SHALL never underflow, since nblk=0 is rejected.

Reset
REQ-038 RST_I=1 SHALL asynchronously reset the following: state IDLE, FIFO empty, pointers 0, blk_left 0, word_cnt 0.
REQ-039 RST_I=1 SHALL asynchronously reset all outputs to 0: busy, fifo_full, ovf, hash_vld, hash_o, core_init, core_vld, core_din.
REQ-040 Reset mid-job SHALL abandon the job with no hash_vld pulse; the core is re-initialised by the next INIT.

Verification
REQ-041 Pre-load 16 words 0x00000001..0x00000010, then start with nblk=1 -> one core_init pulse, then 16 consecutive core_vld cycles carrying words 1..16 in order; core_done with core_hash=H -> hash_o=H, one hash_vld pulse, busy=0.
REQ-042 start nblk=2 with the host pushing 1 word every 3 cycles -> core_vld gaps while the FIFO is empty; no vld between word 16 and core_done; second block starts only after core_done; single hash_vld at the end.
REQ-043 Push DEPTH+1 words in IDLE -> fifo_full=1 after DEPTH words, ovf=1, 17th word absent from the core_din stream; next start -> ovf=0.
REQ-044 Full FIFO during FEED, with push and pop in the same cycle -> no drop, ovf stays 0, fifo_full stays 1.
REQ-045 start with nblk=0 -> busy stays 0, no core_init; start pulse while in WAIT -> ignored, blk_left unchanged.
REQ-046 Assert RST_I during FEED after word 7 -> all outputs 0 within the reset, no hash_vld; a new 1-block job afterwards completes normally.
